// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC op encoding.
package pc_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ   = 3'd0,
    OP_JMP   = 3'd1,
    OP_BRREL = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_HOLD  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH entries with registered full/empty.
// Push is ignored when full, pop is ignored when empty; the counter never wraps.
module pc_ras #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] count_dec_s;
  logic [AW-1:0] top_idx_s;
  logic          full_r;
  logic          empty_r;
  logic [W-1:0]  mem_r [DEPTH];

  // Next occupancy: accepted push increments, accepted pop decrements.
  always_comb begin
    count_nxt_s = count_r;
    count_dec_s = count_r - CW'(1);
    top_idx_s   = count_dec_s[AW-1:0];
    if (push && !full_r) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop && !empty_r) begin
      count_nxt_s = count_dec_s;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Occupancy counter and status flags, flags reflecting the post-edge count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CW'(0);
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == CW'(0));
    end
  end

  // Entry storage; not cleared by reset since occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push && !full_r) begin
      mem_r[count_r[AW-1:0]] <= din;
    end
  end

  assign top   = mem_r[top_idx_s];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, PC register, delayed enable,
// sticky stack error flags, and a return-address stack for CALL/RET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int             W         = 8,
  parameter int             STEP      = 2,
  parameter logic [W-1:0]   RESET_VEC = {{(W-1){1'b1}}, 1'b0},
  parameter int             RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN_L,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    target,
  output logic [W-1:0]    pc_out,
  output logic            PreEN_L,
  output logic            ras_full,
  output logic            ras_empty,
  output logic            err_ovf,
  output logic            err_unf
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] pc_r;
  logic [W-1:0] pc_nxt_s;
  logic [W-1:0] pc_seq_s;
  logic         pre_en_r;
  logic         err_ovf_r;
  logic         err_unf_r;
  logic         adv_s;
  logic         push_s;
  logic         pop_s;
  logic         set_ovf_s;
  logic         set_unf_s;
  logic [W-1:0] ras_top_s;
  logic         ras_full_s;
  logic         ras_empty_s;

  // Next-PC mux and stack request decode; stack is only touched on an advancing edge.
  always_comb begin
    adv_s     = !EN_L && !RESET;
    pc_seq_s  = pc_r + STEP_W;
    pc_nxt_s  = pc_seq_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    set_ovf_s = 1'b0;
    set_unf_s = 1'b0;
    case (op)
      OP_SEQ:   pc_nxt_s = pc_seq_s;
      OP_JMP:   pc_nxt_s = target;
      OP_BRREL: pc_nxt_s = pc_r + target;
      OP_CALL: begin
        pc_nxt_s  = target;
        push_s    = adv_s && !ras_full_s;
        set_ovf_s = ras_full_s;
      end
      OP_RET: begin
        if (ras_empty_s) begin
          pc_nxt_s  = pc_seq_s;
          set_unf_s = 1'b1;
        end else begin
          pc_nxt_s = ras_top_s;
          pop_s    = adv_s;
        end
      end
      OP_HOLD:  pc_nxt_s = pc_r;
      default:  pc_nxt_s = pc_seq_s;
    endcase
  end

  // PC register, delayed enable and sticky error flags; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_r      <= RESET_VEC;
      pre_en_r  <= 1'b1;
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      pre_en_r <= EN_L;
      if (!EN_L) begin
        pc_r      <= pc_nxt_s;
        err_ovf_r <= err_ovf_r | set_ovf_s;
        err_unf_r <= err_unf_r | set_unf_s;
      end
    end
  end

  pc_ras #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (CLK),
    .reset (RESET),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_seq_s),
    .top   (ras_top_s),
    .full  (ras_full_s),
    .empty (ras_empty_s)
  );

  assign pc_out    = pc_r;
  assign PreEN_L   = pre_en_r;
  assign ras_full  = ras_full_s;
  assign ras_empty = ras_empty_s;
  assign err_ovf   = err_ovf_r;
  assign err_unf   = err_unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (W=8, STEP=2, RAS_DEPTH=4) using a
// queue-based reference model plus directed literal expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       EN_L;
  logic [2:0] op;
  logic [7:0] target;
  logic [7:0] pc_out;
  logic       PreEN_L;
  logic       ras_full;
  logic       ras_empty;
  logic       err_ovf;
  logic       err_unf;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int         m_pc;
  int         m_stk[$];
  logic       m_ovf;
  logic       m_unf;
  logic       m_pre;

  pc_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN_L      (EN_L),
    .op        (op),
    .target    (target),
    .pc_out    (pc_out),
    .PreEN_L   (PreEN_L),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 CLK = ~CLK;

  function automatic logic [12:0] obs_vec();
    return {pc_out, PreEN_L, ras_full, ras_empty, err_ovf, err_unf};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] p;
    p = 8'(m_pc);
    return {p, m_pre, (m_stk.size() == 4), (m_stk.size() == 0), m_ovf, m_unf};
  endfunction

  // Drive one cycle, then advance the model by the same rules.
  task automatic apply(input logic r, input logic e, input logic [2:0] o, input logic [7:0] t);
    int off;
    RESET  = r;
    EN_L   = e;
    op     = o;
    target = t;
    @(posedge CLK);
    #1;
    if (r) begin
      m_pc = 254;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_pre = 1'b1;
    end else begin
      m_pre = e;
      if (!e) begin
        off = (t >= 8'd128) ? int'(t) - 256 : int'(t);
        case (o)
          3'd1: m_pc = int'(t);
          3'd2: m_pc = (m_pc + off + 256) % 256;
          3'd3: begin
            if (m_stk.size() < 4) m_stk.push_back((m_pc + 2) % 256);
            else m_ovf = 1'b1;
            m_pc = int'(t);
          end
          3'd4: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
              m_unf = 1'b1;
              m_pc  = (m_pc + 2) % 256;
            end
          end
          3'd5: m_pc = m_pc;
          default: m_pc = (m_pc + 2) % 256;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, OP_CALL, 8'h33);
    apply(1'b1, 1'b0, OP_CALL, 8'h44);
    vectors++;
    if (obs_vec() !== 13'({8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", obs_vec(), 13'({8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] want [3];
    want[0] = 8'h00; want[1] = 8'h02; want[2] = 8'h04;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, OP_SEQ, 8'(i * 17));
      vectors++;
      if (pc_out !== want[i]) begin
        miscompares++;
        $display("FAIL seq_wrap[%0d] got=%h want=%h", i, pc_out, want[i]);
      end
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL seq_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_enable_hold();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, OP_JMP, 8'h80);
      vectors++;
      if (pc_out !== 8'h04 || PreEN_L !== 1'b1) begin
        miscompares++;
        $display("FAIL en_hold[%0d] got pc=%h pre=%b want pc=04 pre=1", i, pc_out, PreEN_L);
      end
    end
    apply(1'b0, 1'b0, OP_HOLD, 8'h80);
    vectors++;
    if (pc_out !== 8'h04 || PreEN_L !== 1'b0) begin
      miscompares++;
      $display("FAIL en_resume got pc=%h pre=%b want pc=04 pre=0", pc_out, PreEN_L);
    end
  endtask

  task automatic test_brrel();
    apply(1'b0, 1'b0, OP_JMP, 8'h10);
    apply(1'b0, 1'b0, OP_BRREL, 8'hF0);
    vectors++;
    if (pc_out !== 8'h00) begin
      miscompares++;
      $display("FAIL brrel_neg got=%h want=00", pc_out);
    end
    apply(1'b0, 1'b0, OP_BRREL, 8'h7F);
    vectors++;
    if (pc_out !== 8'h7F) begin
      miscompares++;
      $display("FAIL brrel_pos got=%h want=7f", pc_out);
    end
  endtask

  task automatic test_call_ret();
    apply(1'b0, 1'b0, OP_JMP, 8'h10);
    apply(1'b0, 1'b0, OP_CALL, 8'h40);
    vectors++;
    if (pc_out !== 8'h40 || ras_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL call got pc=%h empty=%b want pc=40 empty=0", pc_out, ras_empty);
    end
    apply(1'b0, 1'b0, OP_RET, 8'h00);
    vectors++;
    if (pc_out !== 8'h12 || ras_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ret got pc=%h empty=%b want pc=12 empty=1", pc_out, ras_empty);
    end
  endtask

  // Starting from pc=12: pushes 14,22,32,42; fifth CALL is dropped.
  task automatic test_stack_overflow();
    logic [7:0] tg [5];
    logic [7:0] rv [4];
    tg[0] = 8'h20; tg[1] = 8'h30; tg[2] = 8'h40; tg[3] = 8'h50; tg[4] = 8'h60;
    rv[0] = 8'h42; rv[1] = 8'h32; rv[2] = 8'h22; rv[3] = 8'h14;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, OP_CALL, tg[i]);
      vectors++;
      if (pc_out !== tg[i] || ras_full !== (i >= 3) || err_ovf !== (i == 4)) begin
        miscompares++;
        $display("FAIL call_fill[%0d] got pc=%h full=%b ovf=%b want pc=%h full=%b ovf=%b",
                 i, pc_out, ras_full, err_ovf, tg[i], (i >= 3), (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, OP_RET, 8'h00);
      vectors++;
      if (pc_out !== rv[i] || ras_empty !== (i == 3) || err_ovf !== 1'b1) begin
        miscompares++;
        $display("FAIL ret_drain[%0d] got pc=%h empty=%b ovf=%b want pc=%h empty=%b ovf=1",
                 i, pc_out, ras_empty, err_ovf, rv[i], (i == 3));
      end
    end
    apply(1'b0, 1'b0, OP_RET, 8'h00);
    vectors++;
    if (pc_out !== 8'h16 || err_unf !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL ret_underflow got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_priority();
    apply(1'b1, 1'b0, OP_CALL, 8'h70);
    vectors++;
    if (obs_vec() !== 13'({8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})) begin
      miscompares++;
      $display("FAIL reset_prio got=%h want=%h", obs_vec(), 13'({8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    end
    apply(1'b0, 1'b0, OP_RET, 8'h00);
    vectors++;
    if (pc_out !== 8'h00 || err_unf !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_push got pc=%h unf=%b want pc=00 unf=1", pc_out, err_unf);
    end
  endtask

  task automatic test_random();
    logic       r;
    logic       e;
    logic [2:0] o;
    logic [7:0] t;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 25);
      o = 3'($urandom_range(0, 7));
      t = 8'($urandom);
      apply(r, e, o, t);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d en_l=%b rst=%b got=%h want=%h", i, o, e, r, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    RESET  = 1'b1;
    EN_L   = 1'b1;
    op     = OP_SEQ;
    target = 8'h00;
    m_pc   = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_pre  = 1'b1;
    test_reset();
    test_seq_wrap();
    test_enable_hold();
    test_brrel();
    test_call_ret();
    test_stack_overflow();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
